division_operand_feeder: RTL and testbench

//  Upstream stage of the iterative divider: buffers incoming (dividend, divisor) pairs in a small FIFO.

---
 rtl/div_feeder_pkg.sv | 11 +
 rtl/operand_fifo.sv | 40 ++++
 rtl/division_operand_feeder.sv | 78 +++++++
 tb/tb_division_operand_feeder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/div_feeder_pkg.sv
// div_feeder_pkg: shared operand-pair type and width helper for the divider operand feeder.
package div_feeder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] dividend;
    logic [DEF_WIDTH-1:0] divisor;
  } operand_pair_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: DEPTH-entry registered FIFO of packed operand pairs; caller gates push/pop.
module operand_fifo
  import div_feeder_pkg::*;
#(
  parameter int W     = 2 * DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [cnt_w(DEPTH)-1:0]    count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= wdata_i;
  // power-of-two depth lets the pointers wrap for free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + PW'(push_i);
      rd_q    <= rd_q + PW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/division_operand_feeder.sv
// division_operand_feeder: buffers (dividend, divisor) pairs and issues them on independent
// lhs/rhs handshakes, throttled by outstanding results and optionally dropping divide-by-zero.
module division_operand_feeder
  import div_feeder_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DROP_DIV0       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 in_dividend,
  input  logic [WIDTH-1:0]                 in_divisor,
  input  logic                             in_vld,
  output logic                             in_rdy,
  output logic [WIDTH-1:0]                 lhs,
  output logic                             lhs_vld,
  input  logic                             lhs_rdy,
  output logic [WIDTH-1:0]                 rhs,
  output logic                             rhs_vld,
  input  logic                             rhs_rdy,
  input  logic                             res_fire,
  output logic                             div0_err,
  output logic [cnt_w(MAX_OUTSTANDING)-1:0] outstanding,
  output logic [cnt_w(DEPTH)-1:0]          fifo_count
);
  localparam int OW = cnt_w(MAX_OUTSTANDING);
  logic [2*WIDTH-1:0] head;
  logic               empty, full, push, pop, is_div0, committed, drop, issue_ok;
  logic               lhs_fire, rhs_fire, done, dec;
  logic               lhs_sent_q, lhs_sent_d, rhs_sent_q, rhs_sent_d;
  logic [OW-1:0]      outst_q, outst_d;
  operand_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_dividend, in_divisor}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );
  assign in_rdy    = !full;
  assign push      = in_vld && in_rdy;
  assign lhs       = head[2*WIDTH-1:WIDTH];
  assign rhs       = head[WIDTH-1:0];
  assign is_div0   = (DROP_DIV0 != 0) && (rhs == '0);
  assign committed = lhs_sent_q || rhs_sent_q;
  assign drop      = !empty && is_div0 && !committed;
  // a half-accepted pair is never re-gated; it already passed the limit check
  assign issue_ok  = !empty && (committed || (outst_q < OW'(MAX_OUTSTANDING) && !is_div0));
  assign lhs_vld   = issue_ok && !lhs_sent_q;
  assign rhs_vld   = issue_ok && !rhs_sent_q;
  assign lhs_fire  = lhs_vld && lhs_rdy;
  assign rhs_fire  = rhs_vld && rhs_rdy;
  assign done      = (lhs_sent_q || lhs_fire) && (rhs_sent_q || rhs_fire);
  assign pop       = done || drop;
  assign div0_err  = drop;
  assign dec       = res_fire && outst_q != '0;
  assign outstanding = outst_q;
  always_comb begin
    lhs_sent_d = done ? 1'b0 : lhs_sent_q || lhs_fire;
    rhs_sent_d = done ? 1'b0 : rhs_sent_q || rhs_fire;
    outst_d    = outst_q + OW'(done) - OW'(dec);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lhs_sent_q <= 1'b0;
      rhs_sent_q <= 1'b0;
      outst_q    <= '0;
    end else begin
      lhs_sent_q <= lhs_sent_d;
      rhs_sent_q <= rhs_sent_d;
      outst_q    <= outst_d;
    end
endmodule

// File: tb/tb_division_operand_feeder.sv
// tb_division_operand_feeder: directed vector table plus reset-mid-issue sequence.
module tb_division_operand_feeder;
  import div_feeder_pkg::*;
  typedef struct {
    logic [7:0] a, b;
    logic       v, lr, rr, rf;
    logic       e_ir, e_lv, e_rv;
    logic [7:0] e_l, e_r;
    logic       e_err;
    logic [1:0] e_out;
    logic [2:0] e_cnt;
  } vec_t;
  logic       clk = 0, rst = 1;
  logic [7:0] in_dividend = 0, in_divisor = 0, lhs, rhs;
  logic       in_vld = 0, in_rdy, lhs_vld, lhs_rdy = 0, rhs_vld, rhs_rdy = 0, res_fire = 0, div0_err;
  logic [1:0] outstanding;
  logic [2:0] fifo_count;
  int         passed = 0, total = 0;
  vec_t       vq[$];
  division_operand_feeder dut (
    .clk(clk), .rst(rst), .in_dividend(in_dividend), .in_divisor(in_divisor), .in_vld(in_vld),
    .in_rdy(in_rdy), .lhs(lhs), .lhs_vld(lhs_vld), .lhs_rdy(lhs_rdy), .rhs(rhs), .rhs_vld(rhs_vld),
    .rhs_rdy(rhs_rdy), .res_fire(res_fire), .div0_err(div0_err), .outstanding(outstanding),
    .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [7:0] a, b, logic v, lr, rr, rf, ir, lv, rv, logic [7:0] l, r,
                              logic err, logic [1:0] o, logic [2:0] c);
    vec_t x;
    x.a = a; x.b = b; x.v = v; x.lr = lr; x.rr = rr; x.rf = rf;
    x.e_ir = ir; x.e_lv = lv; x.e_rv = rv; x.e_l = l; x.e_r = r; x.e_err = err; x.e_out = o; x.e_cnt = c;
    return x;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic ctl(string nm, logic ir, lv, rv, err, logic [1:0] o, logic [2:0] c);
    chk(nm, {in_rdy, lhs_vld, rhs_vld, div0_err, outstanding, fifo_count}, {ir, lv, rv, err, o, c});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //           a   b  v lr rr rf ir lv rv  l   r err o c
    vq.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(100, 7, 1, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 1, 1, 100, 7, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(20,  3, 1, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0,   0, 0, 1, 0, 0, 1, 1, 1, 20, 3, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 1, 0, 0, 1, 0, 1, 0,  3, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0, 1, 0,  3, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 1, 0, 1, 0, 1, 0,  3, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(9,   0, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(9,   3, 1, 1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 1));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 1, 1, 9,  3, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(1,   1, 1, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(2,   1, 1, 1, 1, 0, 1, 1, 1, 1,  1, 0, 0, 1));
    vq.push_back(mk(3,   1, 1, 1, 1, 0, 1, 1, 1, 2,  1, 0, 1, 1));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 0, 2, 1));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 0, 2, 1));
    vq.push_back(mk(0,   0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 2, 1));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 1, 1, 3,  1, 0, 1, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 2, 0));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(10,  1, 1, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(11,  1, 1, 0, 0, 0, 1, 1, 1, 10, 1, 0, 0, 1));
    vq.push_back(mk(12,  1, 1, 0, 0, 0, 1, 1, 1, 10, 1, 0, 0, 2));
    vq.push_back(mk(13,  1, 1, 0, 0, 0, 1, 1, 1, 10, 1, 0, 0, 3));
    vq.push_back(mk(14,  1, 1, 0, 0, 0, 0, 1, 1, 10, 1, 0, 0, 4));
    vq.push_back(mk(14,  1, 1, 1, 1, 0, 0, 1, 1, 10, 1, 0, 0, 4));
    vq.push_back(mk(14,  1, 1, 1, 1, 0, 1, 1, 1, 11, 1, 0, 1, 3));
    vq.push_back(mk(0,   0, 0, 1, 1, 0, 1, 0, 0, 0,  0, 0, 2, 3));
    vq.push_back(mk(0,   0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 2, 3));
    vq.push_back(mk(0,   0, 0, 1, 1, 1, 1, 1, 1, 12, 1, 0, 1, 3));
    vq.push_back(mk(0,   0, 0, 1, 1, 1, 1, 1, 1, 13, 1, 0, 1, 2));
    vq.push_back(mk(0,   0, 0, 1, 1, 1, 1, 1, 1, 14, 1, 0, 1, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    vq.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(50,  5, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0));
    vq.push_back(mk(0,   0, 0, 0, 1, 0, 1, 1, 1, 50, 5, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 1, 0, 1, 1, 0, 50, 0, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 1, 0, 0, 1, 1, 0, 50, 0, 0, 0, 1));
    vq.push_back(mk(0,   0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    foreach (vq[i]) begin
      in_dividend = vq[i].a; in_divisor = vq[i].b; in_vld = vq[i].v;
      lhs_rdy = vq[i].lr; rhs_rdy = vq[i].rr; res_fire = vq[i].rf;
      #1;
      ctl($sformatf("v%0d.ctl", i), vq[i].e_ir, vq[i].e_lv, vq[i].e_rv, vq[i].e_err, vq[i].e_out, vq[i].e_cnt);
      if (vq[i].e_lv) chk($sformatf("v%0d.lhs", i), 32'(lhs), 32'(vq[i].e_l));
      if (vq[i].e_rv) chk($sformatf("v%0d.rhs", i), 32'(rhs), 32'(vq[i].e_r));
      tick();
    end
    // reset while a pair is half issued
    in_dividend = 60; in_divisor = 6; in_vld = 1; lhs_rdy = 1; rhs_rdy = 0; res_fire = 0;
    tick();
    in_dividend = 61;
    #1 ctl("rst.pre_issue", 1, 1, 1, 0, 0, 1);
    tick();
    in_vld = 0; lhs_rdy = 0;
    #1 ctl("rst.half", 1, 0, 1, 0, 0, 2);
    rst = 1;
    #1 ctl("rst.async", 1, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    #1 ctl("rst.released", 1, 0, 0, 0, 0, 0);
    in_dividend = 70; in_divisor = 7; in_vld = 1;
    tick();
    in_vld = 0; lhs_rdy = 1; rhs_rdy = 1;
    #1 ctl("rst.fresh", 1, 1, 1, 0, 0, 1);
    chk("rst.fresh_lhs", 32'(lhs), 32'd70);
    chk("rst.fresh_rhs", 32'(rhs), 32'd7);
    tick();
    lhs_rdy = 0; rhs_rdy = 0;
    #1 ctl("rst.after_issue", 1, 0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
